// File: rtl/i2c_apb_pkg.sv
// rtl/i2c_apb_pkg.sv - shared constants and helpers for the I2C APB block
package i2c_apb_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 3;

   localparam logic [7:0] REG_TX_DATA = 8'd0;
   localparam logic [7:0] REG_RX_DATA = 8'd4;

   // Pointers carry one extra wrap bit above the array index.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// rtl/i2c_fifo_mem.sv - register-array FIFO storage, sync write, async read
module i2c_fifo_mem
   import i2c_apb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2c_sync_fifo.sv
// rtl/i2c_sync_fifo.sv - show-ahead sync FIFO; FIFO_ERR_FLAGS_EN adds OVERFLOW/UNDERFLOW
module i2c_sync_fifo
   import i2c_apb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AF_LEVEL   = 6
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  W_ENA,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  R_ENA,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  WRITE_FULL,
   output logic                  READ_EMPTY,
   output logic                  ALMOST_FULL,
`ifdef FIFO_ERR_FLAGS_EN
   output logic [ADDR_WIDTH:0]   LEVEL,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
`else
   output logic [ADDR_WIDTH:0]   LEVEL
`endif
);

   localparam int PW = ptr_width(ADDR_WIDTH);

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] head;
   logic                  do_write;
   logic                  do_read;

   assign READ_EMPTY  = (wr_ptr == rd_ptr);
   assign WRITE_FULL  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign LEVEL       = wr_ptr - rd_ptr;
   assign ALMOST_FULL = (LEVEL >= PW'(AF_LEVEL));
   assign DATA_OUT    = READ_EMPTY ? '0 : head;

   // A write while full is dropped even if a read frees a slot this cycle.
   assign do_write = W_ENA && !WRITE_FULL;
   assign do_read  = R_ENA && !READ_EMPTY;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   i2c_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (PCLK),
      .wr_en   (do_write && !PRESET),
      .wr_addr (wr_ptr[PW-2:0]),
      .wr_data (DATA_IN),
      .rd_addr (rd_ptr[PW-2:0]),
      .rd_data (head)
   );

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (W_ENA && WRITE_FULL) OVERFLOW  <= 1'b1;
         if (R_ENA && READ_EMPTY) UNDERFLOW <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_i2c_sync_fifo.sv
// tb/tb_i2c_sync_fifo.sv - randomized queue-model bench for i2c_sync_fifo
module tb_i2c_sync_fifo;

   localparam int DEPTH = 8;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       W_ENA = 1'b0;
   logic [7:0] DATA_IN = 8'h00;
   logic       R_ENA = 1'b0;
   logic [7:0] DATA_OUT;
   logic       WRITE_FULL;
   logic       READ_EMPTY;
   logic       ALMOST_FULL;
   logic [3:0] LEVEL;
`ifdef FIFO_ERR_FLAGS_EN
   logic       OVERFLOW;
   logic       UNDERFLOW;
`endif

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   logic [7:0] q[$];
   bit m_of = 1'b0;
   bit m_uf = 1'b0;

   i2c_sync_fifo dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .W_ENA       (W_ENA),
      .DATA_IN     (DATA_IN),
      .R_ENA       (R_ENA),
      .DATA_OUT    (DATA_OUT),
      .WRITE_FULL  (WRITE_FULL),
      .READ_EMPTY  (READ_EMPTY),
      .ALMOST_FULL (ALMOST_FULL),
`ifdef FIFO_ERR_FLAGS_EN
      .LEVEL       (LEVEL),
      .OVERFLOW    (OVERFLOW),
      .UNDERFLOW   (UNDERFLOW)
`else
      .LEVEL       (LEVEL)
`endif
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference queue: occupancy decided from the pre-edge size.
   always @(posedge PCLK) begin
      int sz;
      sz = q.size();
      if (PRESET) begin
         q.delete();
         m_of = 1'b0;
         m_uf = 1'b0;
      end else begin
         if (W_ENA && sz == DEPTH) m_of = 1'b1;
         if (R_ENA && sz == 0)     m_uf = 1'b1;
         if (R_ENA && sz > 0)      void'(q.pop_front());
         if (W_ENA && sz < DEPTH)  q.push_back(DATA_IN);
      end
   end

   always @(negedge PCLK) begin
      if (check_en) begin
         check("data_out", DATA_OUT, (q.size() > 0) ? q[0] : 8'h00);
         check("level", LEVEL, q.size());
         check("full", WRITE_FULL, q.size() == DEPTH);
         check("empty", READ_EMPTY, q.size() == 0);
         check("almost_full", ALMOST_FULL, q.size() >= 6);
`ifdef FIFO_ERR_FLAGS_EN
         check("overflow", OVERFLOW, m_of);
         check("underflow", UNDERFLOW, m_uf);
`endif
      end
   end

   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rst = 1'b0);
      W_ENA = w;
      DATA_IN = d;
      R_ENA = r;
      PRESET = rst;
      @(posedge PCLK);
      #1;
      W_ENA = 1'b0;
      R_ENA = 1'b0;
      PRESET = 1'b0;
   endtask

   initial begin
      logic [7:0] seq3 [3];
      seq3[0] = 8'h11; seq3[1] = 8'h22; seq3[2] = 8'h33;

      step(0, 8'h00, 0, 1);
      step(1, 8'hEE, 1, 1);
      check_en = 1'b1;
      check("rst_level", LEVEL, 0);
      check("rst_empty", READ_EMPTY, 1);
      check("rst_full", WRITE_FULL, 0);
      check("rst_data", DATA_OUT, 8'h00);

      for (int i = 0; i < 3; i++) begin
         step(1, seq3[i], 0);
         check("fill3_level", LEVEL, i + 1);
      end
      for (int i = 0; i < 3; i++) begin
         check("pop3_data", DATA_OUT, seq3[i]);
         step(0, 8'h00, 1);
         check("pop3_level", LEVEL, 2 - i);
      end
      check("pop3_empty", READ_EMPTY, 1);
      step(0, 8'h00, 1);
      check("pop_empty_data", DATA_OUT, 8'h00);

      for (int i = 0; i < DEPTH; i++) begin
         step(1, 8'hA0 + 8'(i), 0);
         check("af_edge", ALMOST_FULL, (i + 1) >= 6);
      end
      check("full_flag", WRITE_FULL, 1);
      check("full_level", LEVEL, 8);
      step(1, 8'hFF, 0);
      check("ovf_level", LEVEL, 8);
`ifdef FIFO_ERR_FLAGS_EN
      check("ovf_flag", OVERFLOW, 1);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_data", DATA_OUT, 8'hA0 + 8'(i));
         step(0, 8'h00, 1);
      end
      check("drain_empty", READ_EMPTY, 1);

      for (int i = 0; i < DEPTH; i++) step(1, 8'hC0 + 8'(i), 0);
      step(1, 8'h99, 1);
      check("simul_full_level", LEVEL, 7);
      while (q.size() > 0) step(0, 8'h00, 1);

      step(1, 8'h5A, 1);
      check("simul_empty_level", LEVEL, 1);
      check("simul_empty_data", DATA_OUT, 8'h5A);
      for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0);
      step(1, 8'h70, 1);
      check("simul_mid_level", LEVEL, 4);
      while (q.size() > 0) step(0, 8'h00, 1);

      for (int i = 0; i < 20; i++) step(1, 8'(i), (i % 3) != 0);
      while (q.size() > 0) step(0, 8'h00, 1);
      step(0, 8'h00, 1);

      for (int i = 0; i < 5; i++) step(1, 8'h80 + 8'(i), 0);
      check("pre_rst_level", LEVEL, 5);
      step(1, 8'hDD, 0, 1);
      check("mid_rst_level", LEVEL, 0);
      check("mid_rst_empty", READ_EMPTY, 1);
      check("mid_rst_data", DATA_OUT, 8'h00);
`ifdef FIFO_ERR_FLAGS_EN
      check("mid_rst_ovf", OVERFLOW, 0);
      check("mid_rst_unf", UNDERFLOW, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         bit w, r, rst;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         rst = ($urandom_range(0, 299) == 0);
         step(w, 8'($urandom), r, rst);
      end

      @(negedge PCLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_sync_fifo.md
Name: i2c_sync_fifo

Overview:
Single-clock synchronous FIFO that buffers bytes between the APB slave and the I2C byte engine. One instance is the TX path: the APB side writes and the I2C engine reads. A second instance is the RX path: the I2C engine writes and the APB side reads. Produces the WRITE_FULL / READ_EMPTY status that the APB slave uses to gate W_ENA / R_ENA. Read port is show-ahead, so the head byte is valid in the same cycle R_ENA is asserted; this lets the APB slave drive PRDATA combinationally.

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDR_WIDTH, 3, log2 of depth (default depth 8).
AF_LEVEL, 6, ALMOST_FULL asserts when LEVEL >= AF_LEVEL.

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous, active-high reset
W_ENA  in  1  write request, one word per cycle
DATA_IN  in  DATA_WIDTH  write data, sampled when W_ENA=1
R_ENA  in  1  read/pop request, one word per cycle
DATA_OUT  out  DATA_WIDTH  head-of-queue word (show-ahead)
WRITE_FULL  out  1  FIFO holds 2^ADDR_WIDTH words
READ_EMPTY  out  1  FIFO holds 0 words
ALMOST_FULL  out  1  LEVEL >= AF_LEVEL
LEVEL  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH
OVERFLOW  out  1  sticky, present only with FIFO_ERR_FLAGS_EN
UNDERFLOW  out  1  sticky, present only with FIFO_ERR_FLAGS_EN

Behaviour:
- Storage: register array of 2^ADDR_WIDTH x DATA_WIDTH.
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits. The low bits index the array; the MSB is the wrap bit.
- EMPTY when wr_ptr == rd_ptr. FULL when the MSBs differ and the low bits are equal.
- LEVEL = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1). Registered count is permitted if it always matches this value.
- Reset (PRESET=1 at a PCLK edge):
  - wr_ptr = rd_ptr = 0, so LEVEL=0, READ_EMPTY=1, WRITE_FULL=0, ALMOST_FULL=0, DATA_OUT=0.
  - Array contents are not cleared.
  - Reset mid-stream discards all queued data. Any W_ENA/R_ENA in the reset cycle is ignored.
- Write: if W_ENA=1 and not full, mem[wr_ptr] <= DATA_IN and wr_ptr increments at the edge. Visible on DATA_OUT the next cycle if the FIFO was empty (1-cycle write-to-read latency).
- Read: DATA_OUT = mem[rd_ptr] combinationally whenever not empty, and 0 when empty. If R_ENA=1 and not empty, rd_ptr increments at the edge, and DATA_OUT shows the next word in the following cycle.
- Write when full: ignored and data dropped, even if R_ENA=1 in the same cycle. This is deliberately conservative and matches upstream gating.
- Read when empty: ignored, pointers unchanged, DATA_OUT stays 0.
- Simultaneous W_ENA and R_ENA:
  - Neither full nor empty: both take effect and LEVEL is unchanged.
  - Empty: only the write takes effect, LEVEL becomes 1.
  - Full: only the read takes effect, LEVEL becomes max-1.
- Wrap-around: the low pointer bits roll from 2^ADDR_WIDTH-1 to 0 and the MSB toggles. Data order is preserved across the wrap.
- Status outputs are derived from the registered pointers only, never from W_ENA/R_ENA, so there is no combinational path from request to flag.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: OVERFLOW and UNDERFLOW ports exist.
  - OVERFLOW sets on W_ENA=1 while full.
  - UNDERFLOW sets on R_ENA=1 while empty.
  - Both are sticky until PRESET and are registered (assert the cycle after the offending request).
- Undefined: the ports and logic are absent. Illegal requests are still silently ignored.

Decomposition:
- Shared package i2c_apb_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants,
  - the APB register offsets (TX data 8'd0, RX data 8'd4),
  - the pointer type width helper.
- Natural sub-module: i2c_fifo_mem, the register-array storage with a write port and an asynchronous read port.
- Pointer/flag logic stays in i2c_sync_fifo.

Test Plan:
- Reset then idle: READ_EMPTY=1, WRITE_FULL=0, LEVEL=0, DATA_OUT=0.
- Write 0x11,0x22,0x33 on consecutive cycles, then pop 3: DATA_OUT shows 0x11, 0x22, 0x33 in order. LEVEL goes 1,2,3 then 2,1,0, and READ_EMPTY=1 after the third pop.
- Fill 8 words 0xA0..0xA7: WRITE_FULL=1, LEVEL=8, ALMOST_FULL=1 from LEVEL=6. Write 0xFF while full: dropped, and 8 pops return 0xA0..0xA7. With FIFO_ERR_FLAGS_EN, OVERFLOW=1.
- Wrap: interleave 20 writes 0x00..0x13 with pops so the pointers wrap twice. Pop order equals write order, with no loss.
- Simultaneous W_ENA/R_ENA:
  - At LEVEL=4: LEVEL stays 4.
  - At empty, writing 0x5A: LEVEL=1 and DATA_OUT=0x5A next cycle.
  - At full: LEVEL=7 and the write is dropped.
- Assert PRESET with LEVEL=5 while W_ENA=1: next cycle LEVEL=0, READ_EMPTY=1, DATA_OUT=0, and OVERFLOW/UNDERFLOW cleared.
